// File: rtl/axis_adder_arbiter.sv
// axis_adder_arbiter
// Shares one single-transaction AXI-Stream adder among c_NUM_REQ requesters.
// Requesters are granted round-robin. The selected operand pair is issued to
// the adder and the sum is returned tagged with the owner's index. Exactly one
// operation is in flight at a time. Adder results that arrive while idle are
// stale (for example, left in the adder across a reset). They are dropped and
// counted.

module axis_adder_arbiter #(
    parameter int c_WIDTH    = 8,
    parameter int c_NUM_REQ  = 4,
    parameter int c_ID_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [c_NUM_REQ*2*c_WIDTH-1:0] s_req_tdata,
    input  logic [c_NUM_REQ-1:0]           s_req_tvalid,
    output logic [c_NUM_REQ-1:0]           s_req_tready,
    output logic [2*c_WIDTH-1:0]           m_add_tdata,
    output logic                           m_add_tvalid,
    input  logic                           m_add_tready,
    input  logic [c_WIDTH-1:0]             s_res_tdata,
    input  logic                           s_res_tvalid,
    output logic                           s_res_tready,
    output logic [c_WIDTH-1:0]             m_axis_tdata,
    output logic [c_ID_WIDTH-1:0]          m_axis_tid,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [7:0]                     discard_count
);

    localparam int c_PAIR = 2 * c_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    state_t                  state_r;
    logic [c_ID_WIDTH-1:0]   rr_r;
    logic [c_ID_WIDTH-1:0]   grant_r;
    logic [c_PAIR-1:0]       add_data_r;
    logic                    add_vld_r;
    logic [c_WIDTH-1:0]      res_data_r;
    logic [c_ID_WIDTH-1:0]   res_id_r;
    logic                    res_vld_r;
    logic [7:0]              disc_r;

    logic [c_ID_WIDTH-1:0]   grant_s;
    logic                    grant_vld_s;
    logic [c_NUM_REQ-1:0]    req_ready_s;
    logic [c_ID_WIDTH-1:0]   rr_next_s;
    logic [c_PAIR-1:0]       req_data_s [c_NUM_REQ];
    int                      idx_s;

    // The flat operand bus is split into one entry per requester, so the
    // granted pair can be selected with a narrow index.
    for (genvar gi = 0; gi < c_NUM_REQ; gi++) begin : g_req_data
        assign req_data_s[gi] = s_req_tdata[gi*c_PAIR +: c_PAIR];
    end

    // Round-robin search: the first valid requester at or after rr_r, wrapping.
    always_comb begin
        grant_s     = '0;
        grant_vld_s = 1'b0;
        idx_s       = 0;
        for (int k = 0; k < c_NUM_REQ; k++) begin
            idx_s = int'(rr_r) + k;
            if (idx_s >= c_NUM_REQ) begin
                idx_s = idx_s - c_NUM_REQ;
            end else begin
                idx_s = idx_s;
            end
            if (!grant_vld_s && s_req_tvalid[idx_s[c_ID_WIDTH-1:0]]) begin
                grant_s     = idx_s[c_ID_WIDTH-1:0];
                grant_vld_s = 1'b1;
            end else begin
                grant_s     = grant_s;
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Requester ready is the one-hot grant, offered only while idle.
    always_comb begin
        req_ready_s = '0;
        if (state_r == ST_IDLE && grant_vld_s) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // The pointer after a delivery moves to the requester after the owner, modulo c_NUM_REQ.
    always_comb begin
        if (grant_r == c_ID_WIDTH'(c_NUM_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_r + c_ID_WIDTH'(1);
        end
    end

    // Control FSM with the registered stream outputs and the stale-result counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rr_r       <= '0;
            grant_r    <= '0;
            add_data_r <= '0;
            add_vld_r  <= 1'b0;
            res_data_r <= '0;
            res_id_r   <= '0;
            res_vld_r  <= 1'b0;
            disc_r     <= 8'd0;
        end else begin
            if (state_r == ST_IDLE && s_res_tvalid && disc_r != 8'hFF) begin
                disc_r <= disc_r + 8'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        add_data_r <= req_data_s[grant_s];
                        grant_r    <= grant_s;
                        add_vld_r  <= 1'b1;
                        state_r    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_add_tready) begin
                        add_vld_r <= 1'b0;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (s_res_tvalid) begin
                        res_data_r <= s_res_tdata;
                        res_id_r   <= grant_r;
                        res_vld_r  <= 1'b1;
                        state_r    <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (m_axis_tready) begin
                        res_vld_r <= 1'b0;
                        rr_r      <= rr_next_s;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_req_tready  = req_ready_s;
    assign s_res_tready  = (state_r == ST_IDLE) || (state_r == ST_WAIT);
    assign m_add_tdata   = add_data_r;
    assign m_add_tvalid  = add_vld_r;
    assign m_axis_tdata  = res_data_r;
    assign m_axis_tid    = res_id_r;
    assign m_axis_tvalid = res_vld_r;
    assign discard_count = disc_r;

endmodule

// File: doc/axis_adder_arbiter.md
Name: axis_adder_arbiter

Overview:
Round-robin arbiter that shares a single-transaction AXI-Stream adder among c_NUM_REQ requesters. It accepts one operand pair from a requester and issues it to the adder. It then collects the sum and returns it on a result stream tagged with the requester index. It sits between the requester fabric and the adder, and exactly one operation is in flight at a time.

Parameters:
c_WIDTH, 8, operand/result width; adder takes 2*c_WIDTH packed operands and returns c_WIDTH.
c_NUM_REQ, 4, number of requester ports (2..16).
c_ID_WIDTH, 2, width of the result tag; 2**c_ID_WIDTH >= c_NUM_REQ is required.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
s_req_tdata  in  c_NUM_REQ*2*c_WIDTH  requester i operands at slice [i*2W +: 2W].
s_req_tvalid  in  c_NUM_REQ  per-requester valid.
s_req_tready  out  c_NUM_REQ  per-requester ready, at most one bit set.
m_add_tdata  out  2*c_WIDTH  operand pair to adder, registered.
m_add_tvalid  out  1  operand valid to adder.
m_add_tready  in  1  adder ready.
s_res_tdata  in  c_WIDTH  sum from adder.
s_res_tvalid  in  1  sum valid.
s_res_tready  out  1  ready for sum.
m_axis_tdata  out  c_WIDTH  result to requesters, registered.
m_axis_tid  out  c_ID_WIDTH  index of the requester that owns the result.
m_axis_tvalid  out  1  result valid.
m_axis_tready  in  1  downstream ready.
discard_count  out  8  saturating count of stale adder results discarded.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - State goes to IDLE and the rr pointer to 0.
  - m_add_tvalid, m_axis_tvalid, m_add_tdata, m_axis_tdata, m_axis_tid and discard_count all go to 0.
  - Reset mid-operation abandons the operation with no output.
- FSM has four states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - Grant g is the first index with s_req_tvalid set, searching from the rr pointer upward and wrapping modulo c_NUM_REQ.
  - s_req_tready = one-hot(g), combinational, only while some valid is high; otherwise all zero.
  - On a request handshake: latch the operand slice into m_add_tdata, latch g, set m_add_tvalid=1, move to ISSUE.
  - s_res_tready=1 in IDLE. Any s_res_tvalid here is a stale result (e.g. left in the adder across a reset). It is dropped and discard_count increments, saturating at 255. A stale result and a new request in the same cycle are both handled.
- ISSUE:
  - Hold m_add_tdata and m_add_tvalid stable until m_add_tready.
  - On handshake, clear m_add_tvalid and move to WAIT.
- WAIT:
  - s_res_tready=1.
  - On s_res_tvalid, register m_axis_tdata=s_res_tdata, m_axis_tid=g, m_axis_tvalid=1, move to DELIVER.
  - Waits indefinitely; there is no timeout.
- DELIVER:
  - s_res_tready=0; hold outputs stable until m_axis_tready.
  - On handshake, clear m_axis_tvalid, set rr pointer=(g+1) mod c_NUM_REQ, return to IDLE.
- s_req_tready is 0 in ISSUE, WAIT and DELIVER. s_res_tready is 0 in ISSUE and DELIVER.
- Latency with all readies high and a 1-cycle adder:
  - Request accepted at cycle 0.
  - m_add_tvalid high at cycle 1, adder handshake at cycle 1.
  - s_res_tvalid at cycle 2.
  - m_axis_tvalid at cycle 3.
  - Next request accepted at cycle 4. Throughput is 1 op per 4 cycles.
- Arithmetic is performed by the adder only. The sum wraps modulo 2**c_WIDTH and is passed through unchanged.
- The rr pointer only advances on result delivery, so a lone active requester is granted back-to-back.

Test Plan:
- Single request: requester 2 sends {0x03,0x04}, all readies high -> m_add_tdata=0x0304 at cycle 1; m_axis_tdata=0x07, m_axis_tid=2 at cycle 3; s_req_tready[2] high only at cycle 0.
- Fairness: all 4 requesters hold valid with distinct operands -> tids delivered in order 0,1,2,3,0; no requester granted twice before the others.
- Backpressure: hold m_add_tready=0 for 5 cycles, then m_axis_tready=0 for 5 cycles -> m_add_tdata/m_add_tvalid and m_axis_tdata/m_axis_tid/m_axis_tvalid stable throughout; no new s_req_tready during either stall.
- Overflow: requester 1 sends {0xFF,0x02} -> m_axis_tdata=0x01, m_axis_tid=1.
- Reset mid-operation: assert rst in WAIT, then the adder returns 0x55 in IDLE -> result discarded, no m_axis_tvalid, discard_count=1; the next request completes normally with rr pointer starting at 0.
